// File: rtl/pp_pipeline_accel_loop_pipe_body_ctrl.sv
// ---------------------------------------------------------------------------
// pp_pipeline_accel_loop_pipe_body_ctrl
//
// Iteration sequencer for a pipelined loop body. It sits directly downstream
// of the loop flow-control wrapper and turns each accepted start request into
// one issued iteration index. Every issued iteration is then tracked through
// DEPTH pipeline stages, and the retirement of the last iteration of a run is
// reported as loop done.
//
// Parameters
//   TRIP_W  width of trip_count and iter_idx
//   DEPTH   issue-to-retire latency in cycles (>= 1)
//
// Ports
//   ap_clk              clock
//   ap_rst_n            asynchronous active-low reset
//   ap_start_int        start request from the flow-control wrapper
//   ap_loop_init        first-iteration marker, qualified by ap_start_int
//   trip_count          iterations per run, captured on an init issue
//   stall               downstream back-pressure, freezes issue and pipeline
//   iter_idx            index of the iteration issued this cycle
//   iter_issue          an iteration is issued this cycle
//   stage_valid         per-stage occupancy, bit0 = first stage
//   ap_ready_int        pulses once per issued iteration
//   ap_loop_exit_ready  last iteration of the run issued this cycle
//   ap_loop_exit_done   last iteration of the run retired this cycle
//   ap_done_int         same as ap_loop_exit_done
// ---------------------------------------------------------------------------
module pp_pipeline_accel_loop_pipe_body_ctrl #(
   parameter int TRIP_W = 16,
   parameter int DEPTH  = 3
) (
   input  logic              ap_clk,
   input  logic              ap_rst_n,
   input  logic              ap_start_int,
   input  logic              ap_loop_init,
   input  logic [TRIP_W-1:0] trip_count,
   input  logic              stall,
   output logic [TRIP_W-1:0] iter_idx,
   output logic              iter_issue,
   output logic [DEPTH-1:0]  stage_valid,
   output logic              ap_ready_int,
   output logic              ap_loop_exit_ready,
   output logic              ap_loop_exit_done,
   output logic              ap_done_int
);

   // RUN accepts new iterations; DRAIN waits for the last one to retire.
   typedef enum logic {
      ST_RUN   = 1'b0,
      ST_DRAIN = 1'b1
   } state_t;

   state_t              state_q, state_d;
   logic [TRIP_W-1:0]   idx_q, idx_d;
   logic [TRIP_W-1:0]   trip_q, trip_d;
   logic [DEPTH-1:0]    stage_valid_q, stage_valid_d;
   logic [DEPTH-1:0]    last_flag_q, last_flag_d;

   logic                issue;
   logic                init_issue;
   logic                last;
   logic                retire;
   logic [TRIP_W-1:0]   cur;
   logic [TRIP_W-1:0]   trip_new;
   logic [TRIP_W-1:0]   trip_eff;

   // Issue decision and the index/trip values it works with. The issue term
   // is also qualified by ap_rst_n so that the pulse outputs drop the moment
   // reset asserts, even while a start request is still being presented.
   // A zero trip count is promoted to one so such a run still terminates,
   // and an init issue compares against the freshly captured trip value.
   always_comb begin
      issue      = ap_rst_n & ap_start_int & ~stall & (state_q == ST_RUN);
      init_issue = issue & ap_loop_init;
      cur        = ap_loop_init ? '0 : idx_q;
      trip_new   = (trip_count == '0) ? TRIP_W'(1) : trip_count;
      trip_eff   = init_issue ? trip_new : trip_q;
      last       = (cur == (trip_eff - TRIP_W'(1)));
      retire     = stage_valid_q[DEPTH-1] & last_flag_q[DEPTH-1] & ~stall;
   end

   // Next-state logic for the run/drain FSM, the iteration counter and the
   // captured trip count. A last issue and a retire can never coincide,
   // since issue requires RUN and a pending last retire implies DRAIN.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      trip_d  = trip_q;

      if (init_issue) begin
         trip_d = trip_new;
      end

      if (issue) begin
         if (last) begin
            idx_d   = '0;
            state_d = ST_DRAIN;
         end else begin
            idx_d = cur + TRIP_W'(1);
         end
      end else if (retire) begin
         state_d = ST_RUN;
      end
   end

   // Occupancy and last-flag shift registers. Both advance one stage per
   // unstalled cycle and hold completely under stall, so nothing retires
   // while the downstream is back-pressuring.
   always_comb begin
      stage_valid_d = stage_valid_q;
      last_flag_d   = last_flag_q;

      if (!stall) begin
         stage_valid_d[0] = issue;
         last_flag_d[0]   = issue & last;
         for (int i = 1; i < DEPTH; i++) begin
            stage_valid_d[i] = stage_valid_q[i-1];
            last_flag_d[i]   = last_flag_q[i-1];
         end
      end
   end

   // State registers. Reset discards all in-flight iterations, so a run
   // interrupted by reset never produces a done pulse.
   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         state_q       <= ST_RUN;
         idx_q         <= '0;
         trip_q        <= TRIP_W'(1);
         stage_valid_q <= '0;
         last_flag_q   <= '0;
      end else begin
         state_q       <= state_d;
         idx_q         <= idx_d;
         trip_q        <= trip_d;
         stage_valid_q <= stage_valid_d;
         last_flag_q   <= last_flag_d;
      end
   end

   // Output mapping.
   always_comb begin
      iter_idx           = cur;
      iter_issue         = issue;
      ap_ready_int       = issue;
      ap_loop_exit_ready = issue & last;
      ap_loop_exit_done  = retire;
      ap_done_int        = retire;
      stage_valid        = stage_valid_q;
   end

endmodule

// File: tb/tb_pp_pipeline_accel_loop_pipe_body_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pp_pipeline_accel_loop_pipe_body_ctrl
//
// Directed bench for the loop-body iteration sequencer with DEPTH=3. A table
// of per-cycle input/expected-output records covers the normal run, zero trip
// count, stall, back-to-back runs, mid-run trip change and mid-run init. A
// hand-written sequence covers asynchronous reset during a full pipeline.
// ---------------------------------------------------------------------------
module tb_pp_pipeline_accel_loop_pipe_body_ctrl;

   localparam int TRIP_W = 16;
   localparam int DEPTH  = 3;

   logic              ap_clk;
   logic              ap_rst_n;
   logic              ap_start_int;
   logic              ap_loop_init;
   logic [TRIP_W-1:0] trip_count;
   logic              stall;
   logic [TRIP_W-1:0] iter_idx;
   logic              iter_issue;
   logic [DEPTH-1:0]  stage_valid;
   logic              ap_ready_int;
   logic              ap_loop_exit_ready;
   logic              ap_loop_exit_done;
   logic              ap_done_int;

   int testsRun;
   int testsFailed;

   typedef struct {
      logic              start;
      logic              init;
      logic              stl;
      logic [TRIP_W-1:0] trip;
      logic              expIssue;
      logic [TRIP_W-1:0] expIdx;
      logic              expExitReady;
      logic              expDone;
      logic [DEPTH-1:0]  expStage;
   } vec_t;

   vec_t vecs[$];

   pp_pipeline_accel_loop_pipe_body_ctrl #(
      .TRIP_W (TRIP_W),
      .DEPTH  (DEPTH)
   ) dut (
      .ap_clk             (ap_clk),
      .ap_rst_n           (ap_rst_n),
      .ap_start_int       (ap_start_int),
      .ap_loop_init       (ap_loop_init),
      .trip_count         (trip_count),
      .stall              (stall),
      .iter_idx           (iter_idx),
      .iter_issue         (iter_issue),
      .stage_valid        (stage_valid),
      .ap_ready_int       (ap_ready_int),
      .ap_loop_exit_ready (ap_loop_exit_ready),
      .ap_loop_exit_done  (ap_loop_exit_done),
      .ap_done_int        (ap_done_int)
   );

   // 10 ns clock, rising edges at 5, 15, 25, ...
   initial ap_clk = 1'b0;
   always #5 ap_clk = ~ap_clk;

   // Single comparison: counts it and reports a mismatch on one line.
   task checkValue(input string name, input int n, input logic [31:0] act,
                   input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s (step %0d): got %0h, expected %0h", name, n, act, exp);
      end
   endtask

   task addVec(input logic s, input logic i, input logic st, input int tc,
               input logic iss, input int idx, input logic er, input logic dn,
               input logic [DEPTH-1:0] sv);
      vec_t v;
      v.start        = s;
      v.init         = i;
      v.stl          = st;
      v.trip         = TRIP_W'(tc);
      v.expIssue     = iss;
      v.expIdx       = TRIP_W'(idx);
      v.expExitReady = er;
      v.expDone      = dn;
      v.expStage     = sv;
      vecs.push_back(v);
   endtask

   // Drive one record's inputs shortly after a rising edge.
   task applyStimulus(input vec_t v);
      ap_start_int = v.start;
      ap_loop_init = v.init;
      stall        = v.stl;
      trip_count   = v.trip;
   endtask

   // Compare every output against one record; index only when issuing.
   task checkOutput(input int n, input vec_t v);
      checkValue("iter_issue", n, 32'(iter_issue), 32'(v.expIssue));
      checkValue("ap_ready_int", n, 32'(ap_ready_int), 32'(v.expIssue));
      if (v.expIssue)
         checkValue("iter_idx", n, 32'(iter_idx), 32'(v.expIdx));
      checkValue("exit_ready", n, 32'(ap_loop_exit_ready), 32'(v.expExitReady));
      checkValue("exit_done", n, 32'(ap_loop_exit_done), 32'(v.expDone));
      checkValue("done_int", n, 32'(ap_done_int), 32'(v.expDone));
      checkValue("stage_valid", n, 32'(stage_valid), 32'(v.expStage));
   endtask

   initial begin
      testsRun     = 0;
      testsFailed  = 0;
      ap_rst_n     = 1'b0;
      ap_start_int = 1'b0;
      ap_loop_init = 1'b0;
      trip_count   = '0;
      stall        = 1'b0;

      //     start init stall trip | issue idx exitRdy done stage
      // Run of 4, start held, then back-to-back run with trip_count=0
      addVec(1, 1, 0, 4,   1, 0, 0, 0, 3'b000);
      addVec(1, 0, 0, 4,   1, 1, 0, 0, 3'b001);
      addVec(1, 0, 0, 4,   1, 2, 0, 0, 3'b011);
      addVec(1, 0, 0, 4,   1, 3, 1, 0, 3'b111);
      addVec(1, 0, 0, 4,   0, 0, 0, 0, 3'b111);
      addVec(1, 0, 0, 4,   0, 0, 0, 0, 3'b110);
      addVec(1, 1, 0, 0,   0, 0, 0, 1, 3'b100);
      addVec(1, 1, 0, 0,   1, 0, 1, 0, 3'b000);
      addVec(1, 0, 0, 0,   0, 0, 0, 0, 3'b001);
      addVec(1, 0, 0, 0,   0, 0, 0, 0, 3'b010);
      addVec(1, 0, 0, 0,   0, 0, 0, 1, 3'b100);
      addVec(0, 0, 0, 0,   0, 0, 0, 0, 3'b000);
      // Run of 5 with a 2-cycle stall after idx 1, and a stall over retire
      addVec(1, 1, 0, 5,   1, 0, 0, 0, 3'b000);
      addVec(1, 0, 0, 5,   1, 1, 0, 0, 3'b001);
      addVec(1, 0, 1, 5,   0, 0, 0, 0, 3'b011);
      addVec(1, 0, 1, 5,   0, 0, 0, 0, 3'b011);
      addVec(1, 0, 0, 5,   1, 2, 0, 0, 3'b011);
      addVec(1, 0, 0, 5,   1, 3, 0, 0, 3'b111);
      addVec(1, 0, 0, 5,   1, 4, 1, 0, 3'b111);
      addVec(0, 0, 0, 5,   0, 0, 0, 0, 3'b111);
      addVec(0, 0, 0, 5,   0, 0, 0, 0, 3'b110);
      addVec(0, 0, 1, 5,   0, 0, 0, 0, 3'b100);
      addVec(0, 0, 0, 5,   0, 0, 0, 1, 3'b100);
      addVec(0, 0, 0, 5,   0, 0, 0, 0, 3'b000);
      // Run of 6 with trip_count dropped to 2 mid-run, then a run of 2
      addVec(1, 1, 0, 6,   1, 0, 0, 0, 3'b000);
      addVec(1, 0, 0, 2,   1, 1, 0, 0, 3'b001);
      addVec(1, 0, 0, 2,   1, 2, 0, 0, 3'b011);
      addVec(1, 0, 0, 2,   1, 3, 0, 0, 3'b111);
      addVec(1, 0, 0, 2,   1, 4, 0, 0, 3'b111);
      addVec(1, 0, 0, 2,   1, 5, 1, 0, 3'b111);
      addVec(1, 0, 0, 2,   0, 0, 0, 0, 3'b111);
      addVec(1, 0, 0, 2,   0, 0, 0, 0, 3'b110);
      addVec(1, 1, 0, 2,   0, 0, 0, 1, 3'b100);
      addVec(1, 1, 0, 2,   1, 0, 0, 0, 3'b000);
      addVec(1, 0, 0, 2,   1, 1, 1, 0, 3'b001);
      addVec(0, 0, 0, 2,   0, 0, 0, 0, 3'b011);
      addVec(0, 0, 0, 2,   0, 0, 0, 0, 3'b110);
      addVec(0, 0, 0, 2,   0, 0, 0, 1, 3'b100);
      addVec(0, 0, 0, 2,   0, 0, 0, 0, 3'b000);
      // Mid-run init restarts indexing at 0; only the final last retires
      addVec(1, 1, 0, 3,   1, 0, 0, 0, 3'b000);
      addVec(1, 0, 0, 3,   1, 1, 0, 0, 3'b001);
      addVec(1, 1, 0, 3,   1, 0, 0, 0, 3'b011);
      addVec(1, 0, 0, 3,   1, 1, 0, 0, 3'b111);
      addVec(1, 0, 0, 3,   1, 2, 1, 0, 3'b111);
      addVec(0, 0, 0, 3,   0, 0, 0, 0, 3'b111);
      addVec(0, 0, 0, 3,   0, 0, 0, 0, 3'b110);
      addVec(0, 0, 0, 3,   0, 0, 0, 1, 3'b100);
      addVec(0, 0, 0, 3,   0, 0, 0, 0, 3'b000);

      // Reset state, checked while reset is held and a start is presented
      repeat (2) @(posedge ap_clk);
      #1;
      ap_start_int = 1'b1;
      #1;
      checkValue("reset_stage", 0, 32'(stage_valid), 32'd0);
      checkValue("reset_issue", 0, 32'(iter_issue), 32'd0);
      checkValue("reset_done", 0, 32'(ap_done_int), 32'd0);
      ap_start_int = 1'b0;
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      @(posedge ap_clk);
      #1;

      // Table-driven part: inputs after an edge, outputs checked at the
      // falling edge, then advance one cycle.
      for (int n = 0; n < vecs.size(); n++) begin
         applyStimulus(vecs[n]);
         @(negedge ap_clk);
         checkOutput(n, vecs[n]);
         @(posedge ap_clk);
         #1;
      end

      // Asynchronous reset with the pipeline full of a long run.
      ap_start_int = 1'b1;
      ap_loop_init = 1'b1;
      trip_count   = 16'd8;
      stall        = 1'b0;
      @(posedge ap_clk);
      #1;
      ap_loop_init = 1'b0;
      repeat (2) @(posedge ap_clk);
      #1;
      checkValue("rst_pre_stage", 100, 32'(stage_valid), 32'b111);
      checkValue("rst_pre_issue", 100, 32'(iter_issue), 32'd1);
      checkValue("rst_pre_idx", 100, 32'(iter_idx), 32'd3);
      ap_rst_n = 1'b0;
      #1;
      checkValue("rst_async_stage", 101, 32'(stage_valid), 32'd0);
      checkValue("rst_async_issue", 101, 32'(iter_issue), 32'd0);
      checkValue("rst_async_ready", 101, 32'(ap_ready_int), 32'd0);
      checkValue("rst_async_exitrdy", 101, 32'(ap_loop_exit_ready), 32'd0);
      checkValue("rst_async_done", 101, 32'(ap_loop_exit_done), 32'd0);
      for (int k = 0; k < 2; k++) begin
         @(negedge ap_clk);
         checkValue("rst_hold_done", 102 + k, 32'(ap_loop_exit_done), 32'd0);
      end
      ap_rst_n     = 1'b1;
      ap_start_int = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge ap_clk);
         checkValue("rst_after_done", 104 + k, 32'(ap_loop_exit_done), 32'd0);
         checkValue("rst_after_stage", 104 + k, 32'(stage_valid), 32'd0);
      end
      @(posedge ap_clk);
      #1;
      ap_start_int = 1'b1;
      ap_loop_init = 1'b1;
      trip_count   = 16'd2;
      @(negedge ap_clk);
      checkValue("post_rst_issue", 108, 32'(iter_issue), 32'd1);
      checkValue("post_rst_idx", 108, 32'(iter_idx), 32'd0);
      checkValue("post_rst_exitrdy", 108, 32'(ap_loop_exit_ready), 32'd0);
      @(posedge ap_clk);
      #1;
      ap_start_int = 1'b0;
      ap_loop_init = 1'b0;

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
